// File: rtl/conv_pkg.sv
// Shared defaults, pipeline tag type and helper functions for the
// multi-channel convolution accumulate PE.
package conv_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 24;
    localparam int OUT_W_DEF  = 8;

    // Per-stage tags travelling alongside the data path.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    // ceil(log2(n)), never below 1 so a counter always has at least one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Clamp a signed value into the range of a w-bit signed number.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/conv_dot_kk.sv
// KK-lane signed dot product: stage 1 registers the products, stage 2
// registers their sign-extended sum. Tags ride along with the data.
module conv_dot_kk
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int KK     = 25,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  tag_t                    in_tag,
    input  logic [DATA_W*KK-1:0]    pix,
    input  logic [DATA_W*KK-1:0]    wgt,
    output tag_t                    out_tag,
    output logic signed [ACC_W-1:0] out_dot
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0]    prod_d [KK];
    logic signed [PW-1:0]    prod_q [KK];
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] sum_q;
    tag_t                    tag1_q;
    tag_t                    tag2_q;

    // Tap 0 occupies the most significant slice of each bus.
    generate
        for (genvar gi = 0; gi < KK; gi++) begin : g_lane
            logic signed [DATA_W-1:0] p_tap;
            logic signed [DATA_W-1:0] w_tap;
            assign p_tap      = pix[(KK-1-gi)*DATA_W +: DATA_W];
            assign w_tap      = wgt[(KK-1-gi)*DATA_W +: DATA_W];
            assign prod_d[gi] = PW'(p_tap) * PW'(w_tap);
        end
    endgenerate

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < KK; i++) begin
            sum_d = sum_d + {{(ACC_W-PW){prod_q[i][PW-1]}}, prod_q[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag1_q <= '0;
            tag2_q <= '0;
            sum_q  <= '0;
            for (int i = 0; i < KK; i++) begin
                prod_q[i] <= '0;
            end
        end else if (en) begin
            tag1_q <= in_tag;
            tag2_q <= tag1_q;
            sum_q  <= sum_d;
            for (int i = 0; i < KK; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign out_tag = tag2_q;
    assign out_dot = sum_q;

endmodule

// File: rtl/conv_mc_acc_pe.sv
// Multi-channel convolution PE: C_IN window beats per group are dotted,
// accumulated onto a bias, then shifted, optionally ReLU'd and saturated.
module conv_mc_acc_pe
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int K      = 5,
    parameter int C_IN   = 3,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_W*K*K-1:0]          s_pix,
    input  logic [DATA_W*K*K-1:0]          s_wgt,
    input  logic signed [ACC_W-1:0]        bias,
    input  logic [4:0]                     shift,
    input  logic                           relu_en,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic signed [OUT_W-1:0]        m_data,
    output logic signed [ACC_W-1:0]        m_acc,
    output logic [clog2_min1(C_IN)-1:0]    ch_idx
);

    localparam int KK   = K * K;
    localparam int CH_W = clog2_min1(C_IN);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(C_IN - 1);

    generate
        if (ACC_W < 2 * DATA_W + $clog2(KK * C_IN)) begin : g_acc_w_check
            $error("conv_mc_acc_pe: ACC_W too narrow for KK*C_IN products");
        end
    endgenerate

    logic                    en;
    logic                    take;
    logic                    in_first;
    logic                    in_last;
    tag_t                    in_tag;
    tag_t                    tag2;
    logic signed [ACC_W-1:0] dot2;

    logic [CH_W-1:0]         ch_q, ch_d;

    // Group config follows its first beat down the pipe so a following
    // group can be accepted while this one is still finishing.
    logic signed [ACC_W-1:0] bias_p1_q, bias_p2_q;
    logic [4:0]              shift_p1_q, shift_p2_q, shift_g_q;
    logic                    relu_p1_q, relu_p2_q, relu_g_q;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [4:0]              shift_eff;
    logic                    relu_eff;
    logic signed [ACC_W-1:0] q_sh;
    logic signed [OUT_W-1:0] q_out;
    logic                    upd3;
    logic                    load_out;

    logic                    m_valid_q;
    logic signed [OUT_W-1:0] m_data_q;
    logic signed [ACC_W-1:0] m_acc_q;

    assign en       = !m_valid_q || m_ready;
    assign s_ready  = en;
    assign take     = en && s_valid;
    assign in_first = (ch_q == '0);
    assign in_last  = (ch_q == CH_LAST);
    assign in_tag   = '{valid: s_valid, first: in_first, last: in_last};

    always_comb begin
        ch_d = ch_q;
        if (take) begin
            ch_d = in_last ? '0 : ch_q + 1'b1;
        end
    end

    conv_dot_kk #(
        .DATA_W (DATA_W),
        .KK     (KK),
        .ACC_W  (ACC_W)
    ) u_dot (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .in_tag  (in_tag),
        .pix     (s_pix),
        .wgt     (s_wgt),
        .out_tag (tag2),
        .out_dot (dot2)
    );

    assign upd3     = en && tag2.valid;
    assign load_out = upd3 && tag2.last;

    always_comb begin
        shift_eff = tag2.first ? shift_p2_q : shift_g_q;
        relu_eff  = tag2.first ? relu_p2_q  : relu_g_q;
        acc_d     = (tag2.first ? bias_p2_q : acc_q) + dot2;
        q_sh      = acc_d >>> shift_eff;
        if (relu_eff && q_sh[ACC_W-1]) begin
            q_sh = '0;
        end
        q_out = OUT_W'(sat_to(64'(q_sh), OUT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q       <= '0;
            bias_p1_q  <= '0;
            bias_p2_q  <= '0;
            shift_p1_q <= '0;
            shift_p2_q <= '0;
            shift_g_q  <= '0;
            relu_p1_q  <= 1'b0;
            relu_p2_q  <= 1'b0;
            relu_g_q   <= 1'b0;
            acc_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_acc_q    <= '0;
        end else begin
            ch_q <= ch_d;
            if (take && in_first) begin
                bias_p1_q  <= bias;
                shift_p1_q <= shift;
                relu_p1_q  <= relu_en;
            end
            if (en) begin
                bias_p2_q  <= bias_p1_q;
                shift_p2_q <= shift_p1_q;
                relu_p2_q  <= relu_p1_q;
            end
            if (upd3) begin
                acc_q <= acc_d;
                if (tag2.first) begin
                    shift_g_q <= shift_p2_q;
                    relu_g_q  <= relu_p2_q;
                end
            end
            // A fresh result wins over the clear of a consumed one.
            if (load_out) begin
                m_valid_q <= 1'b1;
                m_acc_q   <= acc_d;
                m_data_q  <= q_out;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_acc   = m_acc_q;
    assign ch_idx  = ch_q;

endmodule

// File: tb/tb_conv_mc_acc_pe.sv
// Self-checking bench for conv_mc_acc_pe: directed scenarios plus random
// groups scored against a behavioural group-level reference model.
module tb_conv_mc_acc_pe;

    localparam int DATA_W = 8;
    localparam int K      = 5;
    localparam int KK     = K * K;
    localparam int C_IN   = 3;
    localparam int ACC_W  = 24;
    localparam int OUT_W  = 8;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     s_valid = 1'b0;
    logic                     s_ready;
    logic [DATA_W*KK-1:0]     s_pix = '0;
    logic [DATA_W*KK-1:0]     s_wgt = '0;
    logic signed [ACC_W-1:0]  bias = '0;
    logic [4:0]               shift = '0;
    logic                     relu_en = 1'b0;
    logic                     m_valid;
    logic                     m_ready = 1'b1;
    logic signed [OUT_W-1:0]  m_data;
    logic signed [ACC_W-1:0]  m_acc;
    logic [CH_W-1:0]          ch_idx;

    conv_mc_acc_pe #(
        .DATA_W (DATA_W), .K (K), .C_IN (C_IN), .ACC_W (ACC_W), .OUT_W (OUT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_pix   (s_pix),
        .s_wgt   (s_wgt),
        .bias    (bias),
        .shift   (shift),
        .relu_en (relu_en),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_acc   (m_acc),
        .ch_idx  (ch_idx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: whole-group arithmetic from the rules.
    int     cur_pix [KK];
    int     cur_wgt [KK];
    int     mdl_ch = 0;
    longint mdl_acc = 0;
    int     mdl_sh = 0;
    bit     mdl_relu = 0;
    int     exp_data [$];
    int     exp_acc  [$];
    int     got_data [$];
    int     got_acc  [$];
    int     got_cyc  [$];

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            got_data.push_back(int'(m_data));
            got_acc.push_back(int'(m_acc));
            got_cyc.push_back(cyc);
            $display("[TB] result %0d: m_acc=%0d m_data=%0d", got_data.size() - 1, m_acc, m_data);
        end
    end

    function automatic longint wrap_acc(input longint v);
        longint m;
        m = v & ((longint'(1) << ACC_W) - 1);
        if (m >= (longint'(1) << (ACC_W - 1))) m = m - (longint'(1) << ACC_W);
        return m;
    endfunction

    task automatic model_beat(input int b, input int sh, input bit relu);
        longint dot;
        longint q;
        dot = 0;
        for (int i = 0; i < KK; i++) dot += longint'(cur_pix[i]) * longint'(cur_wgt[i]);
        if (mdl_ch == 0) begin
            mdl_acc  = b;
            mdl_sh   = sh;
            mdl_relu = relu;
        end
        mdl_acc = wrap_acc(mdl_acc + dot);
        if (mdl_ch == C_IN - 1) begin
            q = mdl_acc >>> mdl_sh;
            if (mdl_relu && q < 0) q = 0;
            if (q > 127) q = 127;
            if (q < -128) q = -128;
            exp_data.push_back(int'(q));
            exp_acc.push_back(int'(mdl_acc));
        end
        mdl_ch = (mdl_ch + 1) % C_IN;
    endtask

    task automatic clear_all();
        exp_data.delete(); exp_acc.delete();
        got_data.delete(); got_acc.delete(); got_cyc.delete();
    endtask

    task automatic fill(input int pv, input int wv);
        for (int i = 0; i < KK; i++) begin
            cur_pix[i] = pv;
            cur_wgt[i] = wv;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < KK; i++) begin
            cur_pix[i] = int'($urandom_range(0, 255)) - 128;
            cur_wgt[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send_beat(input int b, input int sh, input bit relu);
        bit rdy;
        bit ok;
        int tmp;
        for (int i = 0; i < KK; i++) begin
            tmp = cur_pix[i];
            s_pix[(KK-1-i)*DATA_W +: DATA_W] = tmp[DATA_W-1:0];
            tmp = cur_wgt[i];
            s_wgt[(KK-1-i)*DATA_W +: DATA_W] = tmp[DATA_W-1:0];
        end
        bias    = b[ACC_W-1:0];
        shift   = sh[4:0];
        relu_en = relu;
        s_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        s_valid = 1'b0;
        if (ok) model_beat(b, sh, relu);
        else begin
            n_tests++; n_fail++;
            $display("FAIL send_beat_timeout s_ready stayed 0, required 1 within 200 cycles");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_results(input int n, output bit ok);
        ok = 0;
        for (int t = 0; t < 400; t++) begin
            if (got_data.size() >= n) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_ch = 0;
        clear_all();
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %0b want 1", s_ready); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        n_tests++; if (m_data !== 0) begin n_fail++; $display("FAIL reset_m_data got %0d want 0", m_data); end
        n_tests++; if (m_acc !== 0) begin n_fail++; $display("FAIL reset_m_acc got %0d want 0", m_acc); end
        n_tests++; if (ch_idx !== 0) begin n_fail++; $display("FAIL reset_ch_idx got %0d want 0", ch_idx); end
    endtask

    task automatic test_basic();
        bit ok;
        clear_all();
        m_ready = 1'b1;
        fill(1, 1);
        for (int c = 0; c < C_IN; c++) begin
            n_tests++;
            if (ch_idx !== c[CH_W-1:0]) begin n_fail++; $display("FAIL basic_ch_idx got %0d want %0d", ch_idx, c); end
            send_beat(0, 0, 0);
        end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat_edge1 m_valid got %0b want 0", m_valid); end
        @(posedge clk); #1;
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat_edge2 m_valid got %0b want 0", m_valid); end
        @(posedge clk); #1;
        n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL basic_lat_edge3 m_valid got %0b want 1", m_valid); end
        n_tests++; if (m_acc !== 75) begin n_fail++; $display("FAIL basic_acc got %0d want 75", m_acc); end
        n_tests++; if (m_data !== 75) begin n_fail++; $display("FAIL basic_data got %0d want 75", m_data); end
        n_tests++; if (ch_idx !== 0) begin n_fail++; $display("FAIL basic_ch_wrap got %0d want 0", ch_idx); end
        wait_results(1, ok);
        idle(2);
    endtask

    task automatic test_sat();
        bit ok;
        clear_all();
        fill(127, 127);
        for (int c = 0; c < C_IN; c++) send_beat(0, 0, 0);
        // Shift only presented on the first beat; it must stick for the group.
        send_beat(0, 14, 0);
        for (int c = 1; c < C_IN; c++) send_beat(0, 0, 0);
        wait_results(2, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL sat_timeout got %0d results want 2", got_data.size()); end
        if (ok) begin
            n_tests++; if (got_acc[0] !== 1209675) begin n_fail++; $display("FAIL sat_acc0 got %0d want 1209675", got_acc[0]); end
            n_tests++; if (got_data[0] !== 127) begin n_fail++; $display("FAIL sat_data_shift0 got %0d want 127", got_data[0]); end
            n_tests++; if (got_acc[1] !== 1209675) begin n_fail++; $display("FAIL sat_acc1 got %0d want 1209675", got_acc[1]); end
            n_tests++; if (got_data[1] !== 73) begin n_fail++; $display("FAIL sat_data_shift14 got %0d want 73", got_data[1]); end
        end
        idle(2);
    endtask

    task automatic test_neg();
        bit ok;
        clear_all();
        fill(-1, 1);
        for (int c = 0; c < C_IN; c++) send_beat(-5, 0, 0);
        send_beat(-5, 0, 1);
        for (int c = 1; c < C_IN; c++) send_beat(0, 0, 0);
        wait_results(2, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL neg_timeout got %0d results want 2", got_data.size()); end
        if (ok) begin
            n_tests++; if (got_acc[0] !== -80) begin n_fail++; $display("FAIL neg_acc got %0d want -80", got_acc[0]); end
            n_tests++; if (got_data[0] !== -80) begin n_fail++; $display("FAIL neg_data_relu_off got %0d want -80", got_data[0]); end
            n_tests++; if (got_acc[1] !== -80) begin n_fail++; $display("FAIL neg_acc_relu got %0d want -80", got_acc[1]); end
            n_tests++; if (got_data[1] !== 0) begin n_fail++; $display("FAIL neg_data_relu_on got %0d want 0", got_data[1]); end
        end
        idle(2);
    endtask

    task automatic test_stall();
        bit ok;
        clear_all();
        fill(1, 1);
        m_ready = 1'b0;
        fork
            begin
                for (int c = 0; c < 2 * C_IN; c++) send_beat(0, 0, 0);
            end
            begin : mon
                bit seen;
                int d0;
                int a0;
                seen = 0;
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (m_valid) begin
                        seen = 1;
                        break;
                    end
                end
                n_tests++; if (!seen) begin n_fail++; $display("FAIL stall_first_valid m_valid got 0 want 1 within 100 cycles"); end
                if (seen) begin
                    d0 = int'(m_data);
                    a0 = int'(m_acc);
                    repeat (5) begin
                        @(negedge clk);
                        n_tests++;
                        if (m_valid !== 1'b1 || int'(m_data) !== d0 || int'(m_acc) !== a0 || s_ready !== 1'b0) begin
                            n_fail++;
                            $display("FAIL stall_hold got v=%0b d=%0d a=%0d rdy=%0b want v=1 d=%0d a=%0d rdy=0",
                                     m_valid, m_data, m_acc, s_ready, d0, a0);
                        end
                    end
                end
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        wait_results(2, ok);
        idle(5);
        n_tests++; if (!ok || got_data.size() != 2) begin n_fail++; $display("FAIL stall_count got %0d results want 2", got_data.size()); end
        if (ok) begin
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (got_acc[i] !== 75 || got_data[i] !== 75) begin
                    n_fail++; $display("FAIL stall_result[%0d] got acc=%0d data=%0d want acc=75 data=75", i, got_acc[i], got_data[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_all();
        fill(1, 1);
        send_beat(0, 0, 0);
        send_beat(0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_ch = 0;
        clear_all();
        n_tests++; if (ch_idx !== 0) begin n_fail++; $display("FAIL rstmid_ch_idx got %0d want 0", ch_idx); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_valid got %0b want 0", m_valid); end
        for (int c = 0; c < C_IN; c++) send_beat(0, 0, 0);
        wait_results(1, ok);
        idle(10);
        n_tests++; if (got_data.size() != 1) begin n_fail++; $display("FAIL rstmid_count got %0d results want 1", got_data.size()); end
        if (ok) begin
            n_tests++;
            if (got_acc[0] !== 75 || got_data[0] !== 75) begin
                n_fail++; $display("FAIL rstmid_result got acc=%0d data=%0d want acc=75 data=75", got_acc[0], got_data[0]);
            end
        end
    endtask

    task automatic test_gaps();
        bit ok;
        clear_all();
        fill(1, 1);
        for (int g = 0; g < 3; g++) begin
            send_beat(10, 0, 0);
            for (int c = 1; c < C_IN; c++) begin
                idle(int'($urandom_range(1, 4)));
                send_beat(int'($urandom_range(0, 1000)) - 500, int'($urandom_range(1, 7)), 1);
            end
            idle(int'($urandom_range(0, 3)));
        end
        wait_results(3, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL gaps_timeout got %0d results want 3", got_data.size()); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (got_acc[i] !== 85 || got_data[i] !== 85) begin
                    n_fail++; $display("FAIL gaps_result[%0d] got acc=%0d data=%0d want acc=85 data=85", i, got_acc[i], got_data[i]);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_all();
        m_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < C_IN; c++) begin
                fill_rand();
                send_beat(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
            end
        end
        wait_results(4, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout got %0d results want 4", got_data.size()); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (got_data[i] !== exp_data[i] || got_acc[i] !== exp_acc[i]) begin
                    n_fail++; $display("FAIL b2b_result[%0d] got data=%0d acc=%0d want data=%0d acc=%0d",
                                       i, got_data[i], got_acc[i], exp_data[i], exp_acc[i]);
                end
                if (i > 0) begin
                    n_tests++;
                    if (got_cyc[i] - got_cyc[i-1] !== C_IN) begin
                        n_fail++; $display("FAIL b2b_spacing[%0d] got %0d cycles want %0d", i, got_cyc[i] - got_cyc[i-1], C_IN);
                    end
                end
            end
        end
        idle(2);
    endtask

    task automatic test_random();
        bit ok;
        bit done;
        int n_grp;
        clear_all();
        done  = 0;
        n_grp = 8;
        fork
            begin
                for (int g = 0; g < n_grp; g++) begin
                    for (int c = 0; c < C_IN; c++) begin
                        fill_rand();
                        send_beat(int'($urandom_range(0, 32'hFFFFFF)) - 32'h800000,
                                  int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
                        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
                m_ready = 1'b1;
            end
        join
        wait_results(n_grp, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rand_timeout got %0d results want %0d", got_data.size(), n_grp); end
        if (ok) begin
            for (int i = 0; i < n_grp; i++) begin
                n_tests++;
                if (got_data[i] !== exp_data[i] || got_acc[i] !== exp_acc[i]) begin
                    n_fail++; $display("FAIL rand_result[%0d] got data=%0d acc=%0d want data=%0d acc=%0d",
                                       i, got_data[i], got_acc[i], exp_data[i], exp_acc[i]);
                end
            end
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat();
        test_neg();
        test_stall();
        test_reset_mid();
        test_gaps();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_mc_acc_pe.md
CONV_MC_ACC_PE -- requirements
Module: conv_mc_acc_pe

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 8, signed pixel/weight width.
REQ-002 K, 5, kernel side; KK = K*K taps per channel.
REQ-003 C_IN, 3, input channels accumulated per output (>=1).
REQ-004 ACC_W, 24, signed accumulator width.
REQ-005 OUT_W, 8, signed quantised output width.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset; synchronous and active-high.
REQ-008 s_valid  in  1  input beat valid.
REQ-009 s_ready  out  1  block accepts a beat.
REQ-010 s_pix  in  DATA_W*KK  one channel window, tap 0 in MSBs.
REQ-011 s_wgt  in  DATA_W*KK  matching weights, tap 0 in MSBs.
REQ-012 bias  in  ACC_W  signed bias, sampled on a group's first beat.
REQ-013 shift  in  5  right-shift amount, sampled on the first beat.
REQ-014 relu_en  in  1  ReLU enable, sampled on the first beat.
REQ-015 m_valid  out  1  result valid.
REQ-016 m_ready  in  1  downstream accepts the result.
REQ-017 m_data  out  OUT_W  quantised result.
REQ-018 m_acc  out  ACC_W  raw accumulated sum.
REQ-019 ch_idx  out  clog2(C_IN) (min 1)  index of the next beat to accept.

Function
REQ-020 A beat transfers on a rising edge with s_valid && s_ready; C_IN consecutive transfers form a group (channel 0..C_IN-1).
REQ-021 Pipeline: stage 1 registers KK signed products (2*DATA_W); stage 2 registers their sign-extended ACC_W sum; stage 3 accumulates.
REQ-022 Each stage carries valid, first and last tags; tags come from the input channel counter.
REQ-023 Stage 3: acc = (first ? bias_s : acc) + dot, modulo 2^ACC_W (wraps, no saturation).
REQ-024 On a last-tagged stage-3 update, the block loads m_acc and m_data and sets m_valid.
REQ-025 Latency: m_valid is high after the 3rd rising edge, counting the last beat's transfer edge as the 1st.
REQ-026 Quantisation: q = acc >>> shift (arithmetic); if relu_en_s and q<0 then q=0; saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-027 Global enable en = !m_valid || m_ready; s_ready = en; all stages and the counter advance only when en=1.
REQ-028 While m_valid && !m_ready: m_valid, m_data and m_acc hold stable, and no beat is lost or duplicated.
REQ-029 m_valid clears on m_valid && m_ready unless a new result loads on the same edge, in which case the new result replaces the old.
REQ-030 Gaps (s_valid=0) between beats of a group insert bubbles and do not alter the result.
REQ-031 ch_idx increments per transfer and wraps from C_IN-1 to 0; with C_IN=1 every beat is both first and last.
REQ-032 bias, shift and relu_en are captured on the first-beat transfer and travel with the group; changes mid-group have no effect.
REQ-033 Full throughput: one beat per cycle with m_ready held high, giving one result every C_IN cycles.

Reset
REQ-034 On rst: s_ready=1 after release; m_valid=0, m_data=0, m_acc=0, ch_idx=0; all stage valids, acc and captured config = 0.
REQ-035 Reset mid-group discards the partial group; the first beat after release is channel 0.

Structure
REQ-036 Shared package conv_pkg holds DATA_W/ACC_W/OUT_W defaults, the saturate function and clog2 helper.
REQ-037 One sub-module, conv_dot_kk: KK-lane multiply plus registered sum, stages 1-2, with enable and tag passthrough.
REQ-038 Elaboration assertion: ACC_W >= 2*DATA_W + clog2(KK*C_IN).

Verification (defaults K=5, C_IN=3)
REQ-039 Pixels=1, weights=1, bias=0, shift=0, relu off, 3 back-to-back beats -> m_acc=75, m_data=75, m_valid after 3rd edge.
REQ-040 Pixels=127, weights=127 -> m_acc=1209675; shift=0 -> m_data=127 (saturated); shift=14 -> m_data=73.
REQ-041 Pixels=-1, weights=1, bias=-5 -> m_acc=-80; relu off m_data=-80; relu on m_data=0.
REQ-042 Two groups back-to-back with m_ready low for 5 cycles at the first m_valid -> outputs hold, s_ready=0 while stalled, then 75 and 75 in order.
REQ-043 Rst pulse after 2 beats of a group, then 3 beats of ones -> single result 75, ch_idx=0 immediately after reset.
REQ-044 Random s_valid gaps within a group of ones plus bias=10 changed mid-group -> result 85 using the first-beat bias.
